sa_output_drain: RTL
====================

# sa_output_drain

Bottom-edge result collector for the systolic array. It samples the `o_bot` partial-sum outputs of every PE column, which arrive skewed by one cycle per column index. It removes the skew so each result row is aligned, buffers completed rows in a small FIFO, and hands them downstream over a valid/ready handshake. It consumes the `o_bot` interface that the PE columns produce.

## Interface
- `ADD_BW`, 32, width of one column result lane (matches PE accumulator width)
- `COLS`, 4, number of array columns; must be ≥2
- `DEPTH`, 4, FIFO depth in rows; power of two, ≥2
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `i_clr` in 1: synchronous clear of delay lines, FIFO and overflow flag; lower priority than `rst`.
- `i_valid` in 1: column-0 result-valid strobe from the array controller.
- `i_bot` in COLS*ADD_BW: packed column bottoms; lane c = `[c*ADD_BW +: ADD_BW]`.
- `o_valid` out 1: FIFO head row available.
- `o_data` out COLS*ADD_BW: FIFO head row, same lane packing.
- `i_ready` in 1: downstream accepts the head row.
- `o_level` out $clog2(DEPTH+1): current FIFO occupancy.
- `o_overflow` out 1: sticky flag, set when an aligned row is dropped.

## Operation
- **Skew model.** For a row whose `i_valid` is high in cycle k, lane c of `i_bot` carries that row's column-c result in cycle k+c.
- **Deskew.**
  - Lane c passes through COLS-1-c register stages.
  - `i_valid` passes through COLS-1 stages.
  - All lanes and the delayed valid are aligned, combinationally, in cycle k+COLS-1.
- **Push.**
  - An aligned valid row is written to the FIFO at the end of cycle k+COLS-1.
  - The write is accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - Otherwise the row is dropped, `o_overflow` sets, and FIFO contents are unchanged.
- **Pop.**
  - A pop occurs when `o_valid && i_ready`.
  - The head advances at the clock edge.
- **FIFO.**
  - Circular buffer with read and write pointers wrapping modulo DEPTH. First-word-fall-through: `o_data` is the head entry whenever `o_valid`=1.
  - When empty: `o_valid`=0 and `o_data`=0.
- **Level update.** Push only: +1. Pop only: −1. Push and pop together: unchanged.
- **Ordering.** Rows emerge in `i_valid` order; there is no reordering.
- **Back-to-back rows.** `i_valid` may be high every cycle. Overlapping skewed rows are handled independently in the delay lines.
- **Clear / reset.**
  - `rst` or `i_clr` zeroes all delay registers, the valid pipe, both pointers, `o_level` and `o_overflow`.
  - Any rows in flight or buffered are discarded.
  - `i_clr` during a partially skewed row: that row never emerges. Rows whose column-0 strobe arrives after the clear are processed normally.
  - `o_overflow` clears only on `rst` or `i_clr`.
- **Arithmetic.** None; lanes are passed bit-exact unless the ReLU feature below is enabled.

## Timing
- **Reset values.** `o_valid`=0, `o_data`=0, `o_level`=0, `o_overflow`=0.
- **Latency.** `i_valid` in cycle k with an empty FIFO gives `o_valid`=1 in cycle k+COLS. That is 4 cycles at COLS=4.
- **Throughput.** One row per cycle in and one out when `i_ready`=1.
- **Handshake.** `o_data` stays stable while `o_valid`=1 and `i_ready`=0. `o_valid` does not depend combinationally on `i_ready`.
- **Status timing.** `o_level` and `o_overflow` are registered and reflect state after the edge.

## Configuration
- **`SA_DRAIN_RELU_EN` defined:** each aligned lane is treated as signed two's complement. A lane with MSB=1 is replaced by 0 before the FIFO write; other lanes pass unchanged. Latency is unchanged.
- **`SA_DRAIN_RELU_EN` undefined:** lanes are stored raw.

## Test plan
All scenarios use COLS=4, DEPTH=4, ADD_BW=32.
1. **Reset.** Hold `rst`=1 for 2 cycles with random `i_bot`/`i_valid` → `o_valid`=0, `o_data`=0, `o_level`=0, `o_overflow`=0.
2. **Single row, deskew and latency.**
   - Stimulus: `i_valid`=1 in cycle 0; lane0=0x11 in cycle 0, lane1=0x22 in cycle 1, lane2=0x33 in cycle 2, lane3=0x44 in cycle 3; `i_ready`=1.
   - Response: `o_valid`=1 in cycle 4 only. `o_data` lanes 0..3 = 0x11, 0x22, 0x33, 0x44. `o_level` reads 1, then 0.
3. **Back-pressure overflow.**
   - Stimulus: `i_ready`=0; 5 consecutive rows tagged 0x1..0x5 in all lanes.
   - Response: `o_level`=4 and `o_overflow`=1. Then raise `i_ready` → rows 0x1..0x4 emerge in order, row 0x5 never appears, `o_overflow` stays 1.
4. **Full with simultaneous push/pop.**
   - Stimulus: fill to 4; assert `i_ready`=1 in the same cycle a 5th aligned row arrives.
   - Response: push accepted, `o_level` stays 4, `o_overflow`=0, row order preserved.
5. **Clear mid-row.**
   - Stimulus: start a row at cycle 0; pulse `i_clr` in cycle 2; start a new row (0xAA in all lanes) at cycle 3.
   - Response: only the 0xAA row emerges, in cycle 7. `o_level` stays ≤1.
6. **ReLU.** Lane0=0xFFFFFFF0, lane1=0x7FFFFFFF → with `SA_DRAIN_RELU_EN`: 0x00000000, 0x7FFFFFFF. Without the macro: both values unchanged.

Source files
------------

// File: rtl/sa_output_drain.sv
// Bottom-edge collector for the systolic array: deskews per-column results into aligned rows
// and buffers them in a first-word-fall-through FIFO. Define SA_DRAIN_RELU_EN to clamp negative lanes to zero.
module sa_output_drain #(
  parameter int ADD_BW = 32,
  parameter int COLS   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_valid,
  input  logic [COLS*ADD_BW-1:0]       i_bot,
  output logic                         o_valid,
  output logic [COLS*ADD_BW-1:0]       o_data,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_overflow
);

  localparam int W     = COLS * ADD_BW;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                flush;
  logic [COLS-2:0]     vpipe;
  logic                aligned_valid;
  logic [ADD_BW-1:0]   aligned [COLS];
  logic [W-1:0]        row_in;

  logic [W-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic                full;
  logic                pop;
  logic                push_ok;
  logic                drop;

  assign flush = rst | i_clr;

  // The valid strobe waits for the last column, which arrives COLS-1 cycles later.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (flush) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= i_valid;
      for (int i = 1; i < COLS - 1; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  assign aligned_valid = vpipe[COLS-2];

  for (genvar c = 0; c < COLS - 1; c++) begin : g_lane
    localparam int D = COLS - 1 - c;
    logic [ADD_BW-1:0] pipe [D];

    always_ff @(posedge clk) begin
      if (flush) begin
        for (int i = 0; i < D; i++) begin
          pipe[i] <= '0;
        end
      end else begin
        pipe[0] <= i_bot[c*ADD_BW +: ADD_BW];
        for (int i = 1; i < D; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign aligned[c] = pipe[D-1];
  end

  // The last column is already aligned when it arrives.
  assign aligned[COLS-1] = i_bot[(COLS-1)*ADD_BW +: ADD_BW];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    row_in = '0;
    for (int c = 0; c < COLS; c++) begin
`ifdef SA_DRAIN_RELU_EN
      row_in[c*ADD_BW +: ADD_BW] = aligned[c][ADD_BW-1] ? '0 : aligned[c];
`else
      row_in[c*ADD_BW +: ADD_BW] = aligned[c];
`endif
    end
  end

  assign full    = (o_level == LVL_W'(DEPTH));
  assign o_valid = (o_level != '0);
  assign pop     = o_valid & i_ready;
  // A full FIFO still accepts a row when the head leaves on the same edge.
  assign push_ok = aligned_valid & (~full | pop);
  assign drop    = aligned_valid & ~push_ok;

  // NOTE: the row storage is deliberately not reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= row_in;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   o_level <= o_level + 1'b1;
        2'b01:   o_level <= o_level - 1'b1;
        default: o_level <= o_level;
      endcase
      o_overflow <= o_overflow | drop;
    end
  end

  assign o_data = o_valid ? mem[rd_ptr] : '0;

endmodule
